// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: clocked command-word front end of a PIC.
//   - Samples CPU bus strobes on clk and commits a write on the WR_n rising edge.
//   - Runs the ICW1 -> ICW2 -> [ICW3] -> [ICW4] init sequence, then decodes OCW1/2/3.
//   - Issues one-cycle command strobes and drives registered read-back data.
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   globalBus, A0, CS_n, WR_n, RD_n CPU bus
//   irr, isr, pollWord              read-back sources
//   ICW1..ICW4, OCW1..OCW3          stored command words (OCW1 is the IMR)
//   initDone                        high once initialisation is complete
//   icw1Strobe .. pollStrobe        one-cycle pulses on the commit cycle
//   readData, readEn                registered read-back data and bus driver enable
module pic_cmd_sequencer #(
  parameter int unsigned        DATA_W    = 8,
  parameter logic [DATA_W-1:0]  RESET_IMR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] globalBus,
  input  logic              A0,
  input  logic              CS_n,
  input  logic              WR_n,
  input  logic              RD_n,
  input  logic [DATA_W-1:0] irr,
  input  logic [DATA_W-1:0] isr,
  input  logic [DATA_W-1:0] pollWord,
  output logic [DATA_W-1:0] ICW1,
  output logic [DATA_W-1:0] ICW2,
  output logic [DATA_W-1:0] ICW3,
  output logic [DATA_W-1:0] ICW4,
  output logic [DATA_W-1:0] OCW1,
  output logic [DATA_W-1:0] OCW2,
  output logic [DATA_W-1:0] OCW3,
  output logic              initDone,
  output logic              icw1Strobe,
  output logic              ocw2Strobe,
  output logic              ocw3Strobe,
  output logic              pollStrobe,
  output logic [DATA_W-1:0] readData,
  output logic              readEn
);

  typedef enum logic [2:0] {StIdle, StWaitIcw2, StWaitIcw3, StWaitIcw4, StReady} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [DATA_W-1:0] ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, read_data_q, read_data_d;
  logic              wr_a0_q, wr_a0_d, wr_armed_q, wr_armed_d;
  logic              wr_n_q, rd_n_q;
  logic              ris_q, ris_d, poll_pending_q, poll_pending_d;
  logic              read_en_q, read_en_d;
  logic [3:0]        strb_q, strb_d;  // {icw1, ocw2, ocw3, poll}
  logic              commit;

  always_comb begin
    state_d        = state_q;
    icw1_d         = icw1_q;
    icw2_d         = icw2_q;
    icw3_d         = icw3_q;
    icw4_d         = icw4_q;
    ocw1_d         = ocw1_q;
    ocw2_d         = ocw2_q;
    ocw3_d         = ocw3_q;
    wr_data_d      = wr_data_q;
    wr_a0_d        = wr_a0_q;
    wr_armed_d     = wr_armed_q;
    ris_d          = ris_q;
    poll_pending_d = poll_pending_q;
    read_data_d    = read_data_q;
    strb_d         = 4'b0000;

    // Latch every active-write cycle; the commit uses whatever was seen last, so an
    // early CS_n release does not cancel the write.
    if (!WR_n && !CS_n) begin
      wr_data_d  = globalBus;
      wr_a0_d    = A0;
      wr_armed_d = 1'b1;
    end

    commit = !wr_n_q && WR_n && wr_armed_q;
    if (commit) wr_armed_d = 1'b0;

    read_en_d = !RD_n && !CS_n;
    if (read_en_d) begin
      if (A0)                  read_data_d = ocw1_q;
      else if (poll_pending_q) read_data_d = pollWord;
      else                     read_data_d = ris_q ? isr : irr;
    end

    // End of an A0=0 read consumes the pending poll word.
    if (!rd_n_q && RD_n && !A0) poll_pending_d = 1'b0;

    // Write path comes last so it wins over the read-side poll clear.
    if (commit) begin
      if (!wr_a0_q && wr_data_q[4]) begin
        icw1_d         = wr_data_q;
        icw2_d         = '0;
        icw3_d         = '0;
        icw4_d         = '0;
        ocw1_d         = RESET_IMR;
        ocw2_d         = '0;
        ocw3_d         = '0;
        ris_d          = 1'b0;
        poll_pending_d = 1'b0;
        strb_d[3]      = 1'b1;
        state_d        = StWaitIcw2;
      end else begin
        case (state_q)
          StWaitIcw2: if (wr_a0_q) begin
            icw2_d = wr_data_q;
            // ICW1[1]=0 means cascaded (ICW3 needed); ICW1[0]=1 means ICW4 needed.
            if (!icw1_q[1])     state_d = StWaitIcw3;
            else if (icw1_q[0]) state_d = StWaitIcw4;
            else                state_d = StReady;
          end
          StWaitIcw3: if (wr_a0_q) begin
            icw3_d  = wr_data_q;
            state_d = icw1_q[0] ? StWaitIcw4 : StReady;
          end
          StWaitIcw4: if (wr_a0_q) begin
            icw4_d  = wr_data_q;
            state_d = StReady;
          end
          StReady: begin
            if (wr_a0_q) begin
              ocw1_d = wr_data_q;
            end else if (wr_data_q[4:3] == 2'b00) begin
              ocw2_d    = wr_data_q;
              strb_d[2] = 1'b1;
            end else if (wr_data_q[4:3] == 2'b01) begin
              ocw3_d    = wr_data_q;
              strb_d[1] = 1'b1;
              if (wr_data_q[1]) ris_d = wr_data_q[0];
              if (wr_data_q[2]) begin
                poll_pending_d = 1'b1;
                strb_d[0]      = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      icw1_q         <= '0;
      icw2_q         <= '0;
      icw3_q         <= '0;
      icw4_q         <= '0;
      ocw1_q         <= RESET_IMR;
      ocw2_q         <= '0;
      ocw3_q         <= '0;
      wr_data_q      <= '0;
      wr_a0_q        <= 1'b0;
      wr_armed_q     <= 1'b0;
      wr_n_q         <= 1'b1;
      rd_n_q         <= 1'b1;
      ris_q          <= 1'b0;
      poll_pending_q <= 1'b0;
      read_data_q    <= '0;
      read_en_q      <= 1'b0;
      strb_q         <= 4'b0000;
    end else begin
      state_q        <= state_d;
      icw1_q         <= icw1_d;
      icw2_q         <= icw2_d;
      icw3_q         <= icw3_d;
      icw4_q         <= icw4_d;
      ocw1_q         <= ocw1_d;
      ocw2_q         <= ocw2_d;
      ocw3_q         <= ocw3_d;
      wr_data_q      <= wr_data_d;
      wr_a0_q        <= wr_a0_d;
      wr_armed_q     <= wr_armed_d;
      wr_n_q         <= WR_n;
      rd_n_q         <= RD_n;
      ris_q          <= ris_d;
      poll_pending_q <= poll_pending_d;
      read_data_q    <= read_data_d;
      read_en_q      <= read_en_d;
      strb_q         <= strb_d;
    end
  end

  assign ICW1       = icw1_q;
  assign ICW2       = icw2_q;
  assign ICW3       = icw3_q;
  assign ICW4       = icw4_q;
  assign OCW1       = ocw1_q;
  assign OCW2       = ocw2_q;
  assign OCW3       = ocw3_q;
  assign initDone   = (state_q == StReady);
  assign icw1Strobe = strb_q[3];
  assign ocw2Strobe = strb_q[2];
  assign ocw3Strobe = strb_q[1];
  assign pollStrobe = strb_q[0];
  assign readData   = read_data_q;
  assign readEn     = read_en_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Scoreboard bench for pic_cmd_sequencer: stimulus pushes expected snapshots / read
// values, the monitor pops and compares when the bus or DUT shows a completed event.
module tb_pic_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] globalBus = 8'h00;
  logic       A0 = 1'b0, CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1;
  logic [7:0] irr = 8'h51, isr = 8'h04, pollWord = 8'h83;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, readData;
  logic       initDone, icw1Strobe, ocw2Strobe, ocw3Strobe, pollStrobe, readEn;

  localparam logic [7:0] RIMR = 8'hF0;

  pic_cmd_sequencer #(.DATA_W(8), .RESET_IMR(RIMR)) dut (
    .clk(clk), .reset(reset), .globalBus(globalBus), .A0(A0), .CS_n(CS_n),
    .WR_n(WR_n), .RD_n(RD_n), .irr(irr), .isr(isr), .pollWord(pollWord),
    .ICW1(ICW1), .ICW2(ICW2), .ICW3(ICW3), .ICW4(ICW4),
    .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3), .initDone(initDone),
    .icw1Strobe(icw1Strobe), .ocw2Strobe(ocw2Strobe), .ocw3Strobe(ocw3Strobe),
    .pollStrobe(pollStrobe), .readData(readData), .readEn(readEn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       init;
    logic [3:0] strb;  // {icw1, ocw2, ocw3, poll}
    logic       is_rst;
  } snap_t;

  snap_t      exp_s, got, e;
  snap_t      wq[$];
  logic [7:0] rq[$];
  logic [7:0] rexp;
  int         total = 0, bad = 0;

  // ---------------- monitor ----------------
  logic wr_prev = 1'b1, pe_commit = 1'b0, pe_rst = 1'b0, chk_low = 1'b0, rd_en_prev = 1'b0;

  always @(posedge clk) begin
    pe_commit <= !wr_prev && WR_n;
    wr_prev   <= WR_n;
    pe_rst    <= reset;
  end

  always @(negedge clk) begin
    got = {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, initDone,
           icw1Strobe, ocw2Strobe, ocw3Strobe, pollStrobe, 1'b0};
    if ((pe_rst && !reset) || pe_commit) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL snap_underflow: got event with empty queue, required queued entry");
      end else begin
        e = wq.pop_front();
        got.is_rst = e.is_rst;
        if (got != e || (e.is_rst && (readData !== 8'h00 || readEn !== 1'b0))) begin
          bad++;
          $display("FAIL %s: got %h rd=%h ren=%b, required %h", e.is_rst ? "reset" : "write",
                   got, readData, readEn, e);
        end
      end
      chk_low <= pe_commit;
    end else if (chk_low) begin
      total++;
      if ({icw1Strobe, ocw2Strobe, ocw3Strobe, pollStrobe} !== 4'b0000) begin
        bad++;
        $display("FAIL strobe_drop: got %b, required 0000",
                 {icw1Strobe, ocw2Strobe, ocw3Strobe, pollStrobe});
      end
      chk_low <= 1'b0;
    end
    if (rd_en_prev && !readEn) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL read_underflow: read ended with empty queue");
      end else begin
        rexp = rq.pop_front();
        if (readData !== rexp) begin
          bad++;
          $display("FAIL read: got %h, required %h", readData, rexp);
        end
      end
    end
    rd_en_prev <= readEn;
  end

  // ---------------- stimulus ----------------
  task automatic push_snap(input logic [3:0] strb);
    snap_t s;
    s = exp_s;
    s.strb = strb;
    s.is_rst = 1'b0;
    wq.push_back(s);
  endtask

  task automatic idle2();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] d, input logic [3:0] strb);
    push_snap(strb);
    CS_n = 1'b0; A0 = a0; globalBus = d; WR_n = 1'b0;
    @(posedge clk); #1;
    WR_n = 1'b1; CS_n = 1'b1;
    @(posedge clk); #1;
    idle2();
  endtask

  // CS_n released one cycle before WR_n, bus changed meanwhile.
  task automatic wr_glitch(input logic a0, input logic [7:0] d, input logic [3:0] strb);
    push_snap(strb);
    CS_n = 1'b0; A0 = a0; globalBus = d; WR_n = 1'b0;
    @(posedge clk); #1;
    CS_n = 1'b1; globalBus = 8'hEE;
    @(posedge clk); #1;
    WR_n = 1'b1;
    @(posedge clk); #1;
    idle2();
  endtask

  task automatic wr_nocs(input logic a0, input logic [7:0] d);
    push_snap(4'b0000);
    CS_n = 1'b1; A0 = a0; globalBus = d; WR_n = 1'b0;
    @(posedge clk); #1;
    WR_n = 1'b1;
    @(posedge clk); #1;
    idle2();
  endtask

  task automatic rd(input logic a0, input logic [7:0] expv);
    rq.push_back(expv);
    CS_n = 1'b0; A0 = a0; RD_n = 1'b0;
    @(posedge clk); #1;
    RD_n = 1'b1; CS_n = 1'b1;
    @(posedge clk); #1;
    idle2();
  endtask

  task automatic do_reset();
    exp_s = '{icw1: 8'h00, icw2: 8'h00, icw3: 8'h00, icw4: 8'h00, ocw1: RIMR,
              ocw2: 8'h00, ocw3: 8'h00, init: 1'b0, strb: 4'b0000, is_rst: 1'b1};
    wq.push_back(exp_s);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle2();
  endtask

  // Expected state after any ICW1 write of value v.
  task automatic exp_icw1(input logic [7:0] v);
    exp_s.icw1 = v; exp_s.icw2 = 8'h00; exp_s.icw3 = 8'h00; exp_s.icw4 = 8'h00;
    exp_s.ocw1 = RIMR; exp_s.ocw2 = 8'h00; exp_s.ocw3 = 8'h00; exp_s.init = 1'b0;
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single, IC4: IDLE -> WAIT_ICW2 -> WAIT_ICW4 -> READY, ICW3 skipped.
    exp_icw1(8'h13);                          wr(1'b0, 8'h13, 4'b1000);
    exp_s.icw2 = 8'h20;                       wr(1'b1, 8'h20, 4'b0000);
    exp_s.icw4 = 8'h01; exp_s.init = 1'b1;    wr(1'b1, 8'h01, 4'b0000);
    rd(1'b0, 8'h51);                          // ris=0 -> irr
    rd(1'b1, RIMR);

    // Operation words.
    exp_s.ocw1 = 8'hA5;                       wr(1'b1, 8'hA5, 4'b0000);
    exp_s.ocw2 = 8'h20;                       wr(1'b0, 8'h20, 4'b0100);
    exp_s.ocw3 = 8'h0B;                       wr(1'b0, 8'h0B, 4'b0010);
    rd(1'b0, 8'h04);                          // ris=1 -> isr
    rd(1'b1, 8'hA5);

    // Poll: clear ris first, then poll command.
    exp_s.ocw3 = 8'h0A;                       wr(1'b0, 8'h0A, 4'b0010);
    exp_s.ocw3 = 8'h0C;                       wr(1'b0, 8'h0C, 4'b0011);
    rd(1'b0, 8'h83);
    rd(1'b0, 8'h51);

    // ICW1 mid-sequence restarts everything.
    exp_icw1(8'h13);                          wr(1'b0, 8'h13, 4'b1000);
    exp_s.icw2 = 8'h20;                       wr(1'b1, 8'h20, 4'b0000);
    exp_icw1(8'h13);                          wr(1'b0, 8'h13, 4'b1000);
    rd(1'b1, RIMR);
    rd(1'b0, 8'h51);

    // Cascade, no IC4.
    exp_icw1(8'h10);                          wr(1'b0, 8'h10, 4'b1000);
    exp_s.icw2 = 8'h08;                       wr(1'b1, 8'h08, 4'b0000);
    wr(1'b0, 8'h08, 4'b0000);                 // A0=0 non-ICW1 in WAIT_ICW3: ignored
    exp_s.icw3 = 8'h04; exp_s.init = 1'b1;    wr(1'b1, 8'h04, 4'b0000);
    exp_s.ocw1 = 8'hFF;                       wr(1'b1, 8'hFF, 4'b0000);

    // Reset in WAIT_ICW3.
    exp_icw1(8'h10);                          wr(1'b0, 8'h10, 4'b1000);
    exp_s.icw2 = 8'h08;                       wr(1'b1, 8'h08, 4'b0000);
    do_reset();

    // IDLE ignores non-ICW1 writes.
    wr(1'b1, 8'h55, 4'b0000);
    wr(1'b0, 8'h08, 4'b0000);

    // Single, no IC4, then bus-glitch cases.
    exp_icw1(8'h12);                          wr(1'b0, 8'h12, 4'b1000);
    exp_s.icw2 = 8'h40; exp_s.init = 1'b1;    wr(1'b1, 8'h40, 4'b0000);
    exp_s.ocw1 = 8'h3C;                       wr_glitch(1'b1, 8'h3C, 4'b0000);
    wr_nocs(1'b1, 8'h99);

    idle2();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", wq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
